// File: rtl/spook_sched_pkg.sv
// spook_sched_pkg
// Shared constants for the Spook round/step scheduler: micro-op encoding,
// FSM state encoding, primitive geometry and the micro-op record that the
// scheduler registers onto its outputs.
package spook_sched_pkg;

    // Primitive geometry
    localparam int NSTEP    = 6;    // steps per primitive
    localparam int NBUNDLE  = 4;    // Shadow bundles per half-step
    localparam int TLS_OPS  = 43;   // Clyde-128 micro-ops per run
    localparam int PERM_OPS = 156;  // Shadow-512 micro-ops per run

    // Micro-op encoding
    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_SBOX = 3'd1;
    localparam logic [2:0] OP_LBOX = 3'd2;
    localparam logic [2:0] OP_RC   = 3'd3;
    localparam logic [2:0] OP_TK   = 3'd4;
    localparam logic [2:0] OP_DIFF = 3'd5;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_TLS_F = 3'd1;
    localparam logic [2:0] ST_TLS_I = 3'd2;
    localparam logic [2:0] ST_PERM  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // One datapath micro-op as seen on the scheduler outputs
    typedef struct packed {
        logic [2:0] op;
        logic [3:0] rc;
        logic [2:0] tk;
        logic [1:0] bundle;
    } uop_t;

    // Round-constant index 2*s + h, built by concatenation so it can never
    // exceed the 4-bit field for s <= 5.
    function automatic logic [3:0] rc_of(input logic [2:0] s, input logic h);
        return {s, h};
    endfunction

endpackage

// File: rtl/sched_cnt.sv
// sched_cnt
// Nested step / half / bundle / phase counter chain for the Spook scheduler.
// It tracks the position of the micro-op being issued and exports the
// position of the op that follows (combinational), so the top can register
// the decoded op in the same edge that advances the chain.
//   Clyde-128 : optional head TK (o_pre), then per step two halves of three
//               phases, then phase 3 (trailing TK). Down-counting for inverse.
//   Shadow-512: per step two halves, each of NBUNDLE bundles x three phases,
//               then phase 3 (DIFF).
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_load          load the start position for a new run
//   i_adv           advance one micro-op
//   i_down, i_perm  run direction / run type, sampled with i_load
//   o_pre, o_s, o_h, o_b, o_p   next-position indices
//   o_last          current position is the final op of the run
module sched_cnt
    import spook_sched_pkg::*;
#(
    parameter int NSTEP_P   = NSTEP,
    parameter int NBUNDLE_P = NBUNDLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic       i_adv,
    input  logic       i_down,
    input  logic       i_perm,
    output logic       o_pre,
    output logic [2:0] o_s,
    output logic       o_h,
    output logic [1:0] o_b,
    output logic [1:0] o_p,
    output logic       o_last
);

    localparam logic [2:0] S_TERM = 3'(NSTEP_P - 1);
    localparam logic [1:0] B_TERM = 2'(NBUNDLE_P - 1);

    logic       r_pre, r_h, r_down, r_perm;
    logic [2:0] r_s;
    logic [1:0] r_b, r_p;

    logic       w_pre, w_h, w_down, w_perm;
    logic [2:0] w_s;
    logic [1:0] w_b, w_p;

    // Next counter position: load a start point, advance, or hold
    always_comb begin
        w_pre  = r_pre;
        w_s    = r_s;
        w_h    = r_h;
        w_b    = r_b;
        w_p    = r_p;
        w_down = r_down;
        w_perm = r_perm;
        if (i_load) begin
            w_perm = i_perm;
            w_down = i_down & ~i_perm;
            w_pre  = ~i_perm;            // Clyde starts with the whitening TK
            w_s    = w_down ? S_TERM : 3'd0;
            w_h    = w_down;             // inverse walks halves 1 then 0
            w_b    = 2'd0;
            w_p    = 2'd0;
        end else if (i_adv) begin
            if (r_perm) begin
                case (r_p)
                    2'd3: begin          // DIFF done: next half or next step
                        w_p = 2'd0;
                        w_b = 2'd0;
                        if (r_h) begin
                            w_h = 1'b0;
                            w_s = (r_s == S_TERM) ? 3'd0 : r_s + 3'd1;
                        end else begin
                            w_h = 1'b1;
                        end
                    end
                    2'd2: begin          // RC done: next bundle or DIFF
                        if (r_b == B_TERM) begin
                            w_p = 2'd3;
                        end else begin
                            w_b = r_b + 2'd1;
                            w_p = 2'd0;
                        end
                    end
                    default: w_p = r_p + 2'd1;
                endcase
            end else if (r_pre) begin
                w_pre = 1'b0;
            end else begin
                case (r_p)
                    2'd3: begin          // trailing TK done: next step
                        w_p = 2'd0;
                        w_h = r_down;
                        if (r_down) begin
                            w_s = (r_s == 3'd0) ? S_TERM : r_s - 3'd1;
                        end else begin
                            w_s = (r_s == S_TERM) ? 3'd0 : r_s + 3'd1;
                        end
                    end
                    2'd2: begin          // second half finished when h differs from direction
                        if (r_h != r_down) begin
                            w_p = 2'd3;
                        end else begin
                            w_h = ~r_h;
                            w_p = 2'd0;
                        end
                    end
                    default: w_p = r_p + 2'd1;
                endcase
            end
        end else begin
            w_pre = r_pre;
        end
    end

    // Counter state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre  <= 1'b0;
            r_s    <= 3'd0;
            r_h    <= 1'b0;
            r_b    <= 2'd0;
            r_p    <= 2'd0;
            r_down <= 1'b0;
            r_perm <= 1'b0;
        end else begin
            r_pre  <= w_pre;
            r_s    <= w_s;
            r_h    <= w_h;
            r_b    <= w_b;
            r_p    <= w_p;
            r_down <= w_down;
            r_perm <= w_perm;
        end
    end

    assign o_pre  = w_pre;
    assign o_s    = w_s;
    assign o_h    = w_h;
    assign o_b    = w_b;
    assign o_p    = w_p;
    assign o_last = r_perm ? ((r_p == 2'd3) && r_h && (r_s == S_TERM))
                           : (!r_pre && (r_p == 2'd3) &&
                              (r_s == (r_down ? 3'd0 : S_TERM)));

endmodule

// File: rtl/spook_round_sched.sv
// spook_round_sched
// Round/step scheduler for the Spook datapath. Issues one micro-op per cycle
// for Clyde-128 (forward/inverse) or Shadow-512 and pulses a done flag in
// the cycle after the last op. Every output comes straight from a register.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   start_tls, start_perm, inv    run requests, sampled only in IDLE
//   op, rc_idx, tk_idx, bundle    current micro-op
//   busy                          run in progress (includes done cycle)
//   tls_done, perm_done           one-cycle completion pulses
module spook_round_sched
    import spook_sched_pkg::*;
#(
    parameter int NSTEP   = spook_sched_pkg::NSTEP,
    parameter int NBUNDLE = spook_sched_pkg::NBUNDLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_tls,
    input  logic       start_perm,
    input  logic       inv,
    output logic [2:0] op,
    output logic [3:0] rc_idx,
    output logic [2:0] tk_idx,
    output logic [1:0] bundle,
    output logic       busy,
    output logic       tls_done,
    output logic       perm_done
);

    logic [2:0] r_state;
    uop_t       r_uop;
    logic       r_busy, r_tls_done, r_perm_done;

    logic [2:0] w_state_n;
    uop_t       w_uop_n;
    logic       w_load, w_adv, w_cnt_down, w_cnt_perm;
    logic       w_tls_done_n, w_perm_done_n;
    logic       w_cnt_pre, w_cnt_h, w_cnt_last;
    logic [2:0] w_cnt_s;
    logic [1:0] w_cnt_b, w_cnt_p;

    sched_cnt #(
        .NSTEP_P   (NSTEP),
        .NBUNDLE_P (NBUNDLE)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_adv  (w_adv),
        .i_down (w_cnt_down),
        .i_perm (w_cnt_perm),
        .o_pre  (w_cnt_pre),
        .o_s    (w_cnt_s),
        .o_h    (w_cnt_h),
        .o_b    (w_cnt_b),
        .o_p    (w_cnt_p),
        .o_last (w_cnt_last)
    );

    // FSM next state and counter control; start_tls has priority over start_perm
    always_comb begin
        w_state_n     = r_state;
        w_load        = 1'b0;
        w_adv         = 1'b0;
        w_cnt_down    = 1'b0;
        w_cnt_perm    = 1'b0;
        w_tls_done_n  = 1'b0;
        w_perm_done_n = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_tls) begin
                    w_load     = 1'b1;
                    w_cnt_down = inv;
                    w_state_n  = inv ? ST_TLS_I : ST_TLS_F;
                end else if (start_perm) begin
                    w_load     = 1'b1;
                    w_cnt_perm = 1'b1;
                    w_state_n  = ST_PERM;
                end else begin
                    w_state_n  = ST_IDLE;
                end
            end
            ST_TLS_F, ST_TLS_I: begin
                if (w_cnt_last) begin
                    w_state_n    = ST_DONE;
                    w_tls_done_n = 1'b1;
                end else begin
                    w_adv = 1'b1;
                end
            end
            ST_PERM: begin
                if (w_cnt_last) begin
                    w_state_n     = ST_DONE;
                    w_perm_done_n = 1'b1;
                end else begin
                    w_adv = 1'b1;
                end
            end
            ST_DONE: w_state_n = ST_IDLE;
            default: w_state_n = ST_IDLE;
        endcase
    end

    // Decode the op for the position the counters move to at this edge
    always_comb begin
        w_uop_n = '0;
        case (w_state_n)
            ST_TLS_F: begin
                if (w_cnt_pre) begin
                    w_uop_n.op = OP_TK;
                    w_uop_n.tk = 3'd0;
                end else begin
                    case (w_cnt_p)
                        2'd0:    w_uop_n.op = OP_SBOX;
                        2'd1:    w_uop_n.op = OP_LBOX;
                        2'd2:    w_uop_n.op = OP_RC;
                        default: w_uop_n.op = OP_TK;
                    endcase
                    if (w_cnt_p == 2'd3) begin
                        w_uop_n.tk = w_cnt_s + 3'd1;
                    end else begin
                        w_uop_n.rc = rc_of(w_cnt_s, w_cnt_h);
                    end
                end
            end
            ST_TLS_I: begin
                if (w_cnt_pre) begin
                    w_uop_n.op = OP_TK;
                    w_uop_n.tk = 3'd6;
                end else begin
                    case (w_cnt_p)
                        2'd0:    w_uop_n.op = OP_RC;
                        2'd1:    w_uop_n.op = OP_LBOX;
                        2'd2:    w_uop_n.op = OP_SBOX;
                        default: w_uop_n.op = OP_TK;
                    endcase
                    if (w_cnt_p == 2'd3) begin
                        w_uop_n.tk = w_cnt_s;
                    end else begin
                        w_uop_n.rc = rc_of(w_cnt_s, w_cnt_h);
                    end
                end
            end
            ST_PERM: begin
                w_uop_n.rc = rc_of(w_cnt_s, w_cnt_h);
                case (w_cnt_p)
                    2'd0:    w_uop_n.op = OP_SBOX;
                    2'd1:    w_uop_n.op = OP_LBOX;
                    2'd2:    w_uop_n.op = OP_RC;
                    default: w_uop_n.op = OP_DIFF;
                endcase
                if (w_cnt_p == 2'd3) begin
                    w_uop_n.bundle = 2'd0;
                end else begin
                    w_uop_n.bundle = w_cnt_b;
                end
            end
            default: w_uop_n = '0;     // IDLE and DONE issue NOP with zero fields
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_uop       <= '0;
            r_busy      <= 1'b0;
            r_tls_done  <= 1'b0;
            r_perm_done <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_uop       <= w_uop_n;
            r_busy      <= (w_state_n != ST_IDLE);
            r_tls_done  <= w_tls_done_n;
            r_perm_done <= w_perm_done_n;
        end
    end

    assign op        = r_uop.op;
    assign rc_idx    = r_uop.rc;
    assign tk_idx    = r_uop.tk;
    assign bundle    = r_uop.bundle;
    assign busy      = r_busy;
    assign tls_done  = r_tls_done;
    assign perm_done = r_perm_done;

endmodule

// File: tb/tb_spook_round_sched.sv
// tb_spook_round_sched
// Directed bench for spook_round_sched. Expected op streams are built from
// the Clyde/Shadow loop structure with local op codes; rc_idx is not
// compared on TK and DIFF ops, where it carries no meaning.
module tb_spook_round_sched;

    localparam logic [2:0] E_NOP  = 3'd0;
    localparam logic [2:0] E_SBOX = 3'd1;
    localparam logic [2:0] E_LBOX = 3'd2;
    localparam logic [2:0] E_RC   = 3'd3;
    localparam logic [2:0] E_TK   = 3'd4;
    localparam logic [2:0] E_DIFF = 3'd5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_tls = 1'b0;
    logic       start_perm = 1'b0;
    logic       inv = 1'b0;
    logic [2:0] op;
    logic [3:0] rc_idx;
    logic [2:0] tk_idx;
    logic [1:0] bundle;
    logic       busy, tls_done, perm_done;

    int n_total = 0;
    int n_bad   = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    spook_round_sched dut (
        .clk        (clk),
        .rst        (rst),
        .start_tls  (start_tls),
        .start_perm (start_perm),
        .inv        (inv),
        .op         (op),
        .rc_idx     (rc_idx),
        .tk_idx     (tk_idx),
        .bundle     (bundle),
        .busy       (busy),
        .tls_done   (tls_done),
        .perm_done  (perm_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // kind: 0 forward Clyde, 1 inverse Clyde, 2 Shadow
    task automatic build(input int kind);
        exp_q.delete();
        if (kind == 0) begin
            exp_q.push_back({E_TK, 4'd0, 3'd0, 2'd0});
            for (int s = 0; s < 6; s++) begin
                for (int r = 0; r < 2; r++) begin
                    exp_q.push_back({E_SBOX, 4'(2*s+r), 3'd0, 2'd0});
                    exp_q.push_back({E_LBOX, 4'(2*s+r), 3'd0, 2'd0});
                    exp_q.push_back({E_RC,   4'(2*s+r), 3'd0, 2'd0});
                end
                exp_q.push_back({E_TK, 4'd0, 3'(s+1), 2'd0});
            end
        end else if (kind == 1) begin
            exp_q.push_back({E_TK, 4'd0, 3'd6, 2'd0});
            for (int s = 5; s >= 0; s--) begin
                for (int r = 1; r >= 0; r--) begin
                    exp_q.push_back({E_RC,   4'(2*s+r), 3'd0, 2'd0});
                    exp_q.push_back({E_LBOX, 4'(2*s+r), 3'd0, 2'd0});
                    exp_q.push_back({E_SBOX, 4'(2*s+r), 3'd0, 2'd0});
                end
                exp_q.push_back({E_TK, 4'd0, 3'(s), 2'd0});
            end
        end else begin
            for (int s = 0; s < 6; s++) begin
                for (int h = 0; h < 2; h++) begin
                    for (int b = 0; b < 4; b++) begin
                        exp_q.push_back({E_SBOX, 4'(2*s+h), 3'd0, 2'(b)});
                        exp_q.push_back({E_LBOX, 4'(2*s+h), 3'd0, 2'(b)});
                        exp_q.push_back({E_RC,   4'(2*s+h), 3'd0, 2'(b)});
                    end
                    exp_q.push_back({E_DIFF, 4'(2*s+h), 3'd0, 2'd0});
                end
            end
        end
    endtask

    // Entered sampling cycle t+1 of an accepted start; walks the run, the
    // done cycle and the following IDLE cycle.
    task automatic expect_run(input int kind, input string name);
        logic [11:0] obs;
        logic [11:0] e;
        logic [11:0] m;
        logic        want_tls;
        build(kind);
        want_tls = (kind != 2);
        if (exp_q.size() != ((kind == 2) ? 156 : 43)) begin
            n_bad++;
            $display("FAIL %s_len: model length %0d", name, exp_q.size());
        end
        foreach (exp_q[i]) begin
            e   = exp_q[i];
            obs = {op, rc_idx, tk_idx, bundle};
            m   = (e[11:9] == E_TK || e[11:9] == E_DIFF) ? 12'hE1F : 12'hFFF;
            n_total++;
            if (((obs ^ e) & m) !== 12'd0 || busy !== 1'b1 ||
                tls_done !== 1'b0 || perm_done !== 1'b0) begin
                n_bad++;
                $display("FAIL %s_op%0d: got op=%0d rc=%0d tk=%0d b=%0d busy=%b done=%b%b, want op=%0d rc=%0d tk=%0d b=%0d busy=1 done=00",
                         name, i, op, rc_idx, tk_idx, bundle, busy, tls_done, perm_done,
                         e[11:9], e[8:5], e[4:2], e[1:0]);
            end
            tick();
        end
        n_total++;
        if ({op, rc_idx, tk_idx, bundle} !== 12'd0 || busy !== 1'b1 ||
            tls_done !== want_tls || perm_done !== !want_tls) begin
            n_bad++;
            $display("FAIL %s_done: got op=%0d fields=%h busy=%b tls_done=%b perm_done=%b, want NOP busy=1 tls_done=%b perm_done=%b",
                     name, op, {rc_idx, tk_idx, bundle}, busy, tls_done, perm_done, want_tls, !want_tls);
        end
        tick();
        n_total++;
        if ({op, rc_idx, tk_idx, bundle} !== 12'd0 || busy !== 1'b0 ||
            tls_done !== 1'b0 || perm_done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle: got op=%0d busy=%b done=%b%b, want NOP busy=0 done=00",
                     name, op, busy, tls_done, perm_done);
        end
    endtask

    task automatic test_reset;
        tick();
        tick();
        n_total++;
        if ({op, rc_idx, tk_idx, bundle, busy, tls_done, perm_done} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_hold: got op=%0d rc=%0d tk=%0d b=%0d busy=%b done=%b%b, want all 0",
                     op, rc_idx, tk_idx, bundle, busy, tls_done, perm_done);
        end
        rst = 1'b1;
        tick();
        n_total++;
        if ({op, rc_idx, tk_idx, bundle, busy, tls_done, perm_done} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_release: got op=%0d busy=%b, want 0/0", op, busy);
        end
    endtask

    task automatic test_fwd;
        inv = 1'b0;
        start_tls = 1'b1;
        tick();
        start_tls = 1'b0;
        expect_run(0, "fwd");
    endtask

    task automatic test_inv;
        inv = 1'b1;
        start_tls = 1'b1;
        tick();
        start_tls = 1'b0;
        inv = 1'b0;
        expect_run(1, "inv");
    endtask

    task automatic test_perm;
        start_perm = 1'b1;
        tick();
        start_perm = 1'b0;
        expect_run(2, "perm");
    endtask

    // Both starts together, then start_perm held through the run and its done
    // cycle; it must only take effect in the IDLE cycle that follows.
    task automatic test_back_to_back;
        inv = 1'b0;
        start_tls = 1'b1;
        start_perm = 1'b1;
        tick();
        start_tls = 1'b0;
        expect_run(0, "both");
        tick();
        start_perm = 1'b0;
        expect_run(2, "idle_restart");
    endtask

    task automatic test_reset_midrun;
        start_perm = 1'b1;
        tick();
        start_perm = 1'b0;
        repeat (79) tick();
        n_total++;
        if (busy !== 1'b1 || op === E_NOP) begin
            n_bad++;
            $display("FAIL midrun_active: got op=%0d busy=%b, want running op busy=1", op, busy);
        end
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if ({op, rc_idx, tk_idx, bundle, busy, tls_done, perm_done} !== 15'd0) begin
            n_bad++;
            $display("FAIL midrun_async: got op=%0d rc=%0d tk=%0d b=%0d busy=%b done=%b%b, want all 0",
                     op, rc_idx, tk_idx, bundle, busy, tls_done, perm_done);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++;
            if ({op, rc_idx, tk_idx, bundle, busy, tls_done, perm_done} !== 15'd0) begin
                n_bad++;
                $display("FAIL post_reset_idle%0d: got op=%0d busy=%b done=%b%b, want all 0",
                         k, op, busy, tls_done, perm_done);
            end
        end
        start_tls = 1'b1;
        tick();
        start_tls = 1'b0;
        expect_run(0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_fwd();
        test_inv();
        test_perm();
        test_back_to_back();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
